// File: rtl/conv_weight_pkg.sv
// Shared constants, state encoding and address helper for the conv3_1 weight sequencer.
// Optional build macro used by this slice: WEIGHT_CKSUM_EN (per-set checksum).
package conv_weight_pkg;

  localparam int unsigned KERNEL_WORDS = 36;  // 3x3x4 words per kernel set
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned NUM_KERNELS  = 8;
  localparam int unsigned ADDR_W       = 9;   // 2^ADDR_W must cover NUM_KERNELS*KERNEL_WORDS

  localparam int unsigned KBUS_W  = KERNEL_WORDS * DATA_W;
  localparam int unsigned KIDX_W  = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam int unsigned CKSUM_W = DATA_W + 6;
  localparam int unsigned WCNT_W  = $clog2(KERNEL_WORDS + 1);
  localparam int unsigned CAP_W   = $clog2(KERNEL_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // First ROM word address of kernel set k.
  function automatic logic [ADDR_W-1:0] set_base(input logic [KIDX_W-1:0] k);
    return ADDR_W'(32'(k) * KERNEL_WORDS);
  endfunction

endpackage

// File: rtl/conv_weight_sequencer_if.sv
// Kernel-set bus from the weight sequencer (master) to the conv3 PE array (slave).
interface conv_weight_sequencer_if;
  import conv_weight_pkg::*;

  // Valid/ready: a set transfers on a clock edge where kernel_valid && kernel_ready.
  // While kernel_valid is high the master holds data/idx/cksum stable; ready alone does nothing.
  logic                kernel_valid;
  logic                kernel_ready;
  logic [KBUS_W-1:0]   kernel_data;
  logic [KIDX_W-1:0]   kernel_idx;
  logic [CKSUM_W-1:0]  kernel_cksum;

  modport master (
    output kernel_valid,
    output kernel_data,
    output kernel_idx,
    output kernel_cksum,
    input  kernel_ready
  );

  modport slave (
    input  kernel_valid,
    input  kernel_data,
    input  kernel_idx,
    input  kernel_cksum,
    output kernel_ready
  );

endinterface

// File: rtl/weight_capture_buf.sv
// Lands each ROM word (returned one cycle after its read strobe) into the next kernel slot.
// With WEIGHT_CKSUM_EN defined, also keeps a running sum of the captured words.
module weight_capture_buf
  import conv_weight_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                rd_en_i,
  input  logic [DATA_W-1:0]   rd_data_i,
  output logic                last_o,
  output logic [KBUS_W-1:0]   data_o,
  output logic [CKSUM_W-1:0]  cksum_o
);

  logic              rd_vld_q;
  logic [CAP_W-1:0]  cap_cnt_q;
  logic [CAP_W-1:0]  cap_cnt_d;
  logic [DATA_W-1:0] slot_q [KERNEL_WORDS];

  assign last_o = rd_vld_q && (cap_cnt_q == CAP_W'(KERNEL_WORDS - 1));

  always_comb begin
    cap_cnt_d = cap_cnt_q;
    if (clr_i) begin
      cap_cnt_d = '0;
    end else if (rd_vld_q) begin
      cap_cnt_d = last_o ? '0 : cap_cnt_q + CAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      cap_cnt_q <= '0;
      for (int i = 0; i < int'(KERNEL_WORDS); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      rd_vld_q  <= rd_en_i;
      cap_cnt_q <= cap_cnt_d;
      if (rd_vld_q) begin
        slot_q[cap_cnt_q] <= rd_data_i;
      end
    end
  end

  for (genvar g = 0; g < KERNEL_WORDS; g++) begin : g_pack
    assign data_o[g*DATA_W +: DATA_W] = slot_q[g];
  end

`ifdef WEIGHT_CKSUM_EN
  logic [CKSUM_W-1:0] cksum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cksum_q <= '0;
    end else if (clr_i) begin
      cksum_q <= '0;
    end else if (rd_vld_q) begin
      cksum_q <= cksum_q + CKSUM_W'(rd_data_i);
    end
  end

  assign cksum_o = cksum_q;
`else
  assign cksum_o = '0;
`endif

endmodule

// File: rtl/conv_weight_sequencer.sv
// Reads NUM_KERNELS kernel sets from the weight ROM and presents each as one wide bus.
// Checksum output is live only when built with WEIGHT_CKSUM_EN.
module conv_weight_sequencer
  import conv_weight_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      rom_rd_en_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic [DATA_W-1:0]         rom_data_i,
  conv_weight_sequencer_if.master   kif,
  output state_t                    state_o
);

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 rd_en_q;
  logic                 valid_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WCNT_W-1:0]    wcnt_q;
  logic [KIDX_W-1:0]    kidx_q;

  logic                 accept;
  logic                 last_set;
  logic                 cap_clr;
  logic                 cap_last;
  logic [KBUS_W-1:0]    cap_data;
  logic [CKSUM_W-1:0]   cap_cksum;

  assign accept   = valid_q && kif.kernel_ready;
  assign last_set = (kidx_q == KIDX_W'(NUM_KERNELS - 1));
  // Pulses on every edge that enters FETCH, so the capture side starts each set clean.
  assign cap_clr  = ((state_q == IDLE) && start_i) ||
                    ((state_q == HOLD) && accept && !last_set);

  // wcnt_q counts reads already issued in this set; reads run back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      kidx_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
            kidx_q  <= '0;
            rd_en_q <= 1'b1;
            addr_q  <= set_base('0);
            wcnt_q  <= WCNT_W'(1);
          end
        end
        FETCH: begin
          if (wcnt_q != WCNT_W'(KERNEL_WORDS)) begin
            rd_en_q <= 1'b1;
            addr_q  <= addr_q + ADDR_W'(1);
            wcnt_q  <= wcnt_q + WCNT_W'(1);
          end else begin
            rd_en_q <= 1'b0;
          end
          if (cap_last) begin
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            valid_q <= 1'b0;
            if (last_set) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              kidx_q  <= kidx_q + KIDX_W'(1);
              state_q <= FETCH;
              rd_en_q <= 1'b1;
              addr_q  <= set_base(kidx_q + KIDX_W'(1));
              wcnt_q  <= WCNT_W'(1);
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  weight_capture_buf u_capture (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cap_clr),
    .rd_en_i   (rd_en_q),
    .rd_data_i (rom_data_i),
    .last_o    (cap_last),
    .data_o    (cap_data),
    .cksum_o   (cap_cksum)
  );

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign rom_rd_en_o      = rd_en_q;
  assign rom_addr_o       = addr_q;
  assign state_o          = state_q;
  assign kif.kernel_valid = valid_q;
  assign kif.kernel_data  = cap_data;
  assign kif.kernel_idx   = kidx_q;
  assign kif.kernel_cksum = cap_cksum;

endmodule

// File: tb/tb_conv_weight_sequencer.sv
// Directed bench for conv_weight_sequencer: ROM model word(a)=a+1, scoreboard of expected sets.
module tb_conv_weight_sequencer;
  import conv_weight_pkg::*;

`ifdef WEIGHT_CKSUM_EN
  localparam logic [CKSUM_W-1:0] CK_SET0 = CKSUM_W'(666);
  localparam logic [CKSUM_W-1:0] CK_SET7 = CKSUM_W'(9738);
`else
  localparam logic [CKSUM_W-1:0] CK_SET0 = '0;
  localparam logic [CKSUM_W-1:0] CK_SET7 = '0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              rom_rd_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  state_t            state;

  conv_weight_sequencer_if kif ();

  conv_weight_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .rom_rd_en_o (rom_rd_en),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .kif         (kif),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_rd_en) rom_data <= DATA_W'(rom_addr) + DATA_W'(1);
  end

  // ---------------- scoreboard ----------------
  logic [KBUS_W-1:0]  exp_q[$];
  logic [KIDX_W-1:0]  exp_idx_q[$];
  logic [CKSUM_W-1:0] exp_ck_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int rd_base;
  int n;
  int dc;
  logic seen7;
  logic [KBUS_W-1:0] snap;

  function automatic logic [KBUS_W-1:0] exp_set(input int k);
    logic [KBUS_W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(KERNEL_WORDS); i++)
      v[i*DATA_W +: DATA_W] = DATA_W'(k * int'(KERNEL_WORDS) + i + 1);
    return v;
  endfunction

  function automatic logic [CKSUM_W-1:0] exp_ck(input int k);
`ifdef WEIGHT_CKSUM_EN
    int s;
    s = 0;
    for (int i = 0; i < int'(KERNEL_WORDS); i++) s += k * int'(KERNEL_WORDS) + i + 1;
    return CKSUM_W'(s);
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_run();
    for (int k = 0; k < int'(NUM_KERNELS); k++) begin
      exp_q.push_back(exp_set(k));
      exp_idx_q.push_back(KIDX_W'(k));
      exp_ck_q.push_back(exp_ck(k));
    end
  endtask

  // One clock: monitor at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (done) done_cnt++;
    if (rom_rd_en) rd_cnt++;
    if (kif.kernel_valid) begin
      chk("rd_en_in_hold", 64'(rom_rd_en), 64'(0));
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_set observed=idx%0d expected=no_set", kif.kernel_idx);
      end
      if (exp_q.size() != 0) begin
        checks++;
        assert (kif.kernel_data === exp_q[0]) else begin
          errors++;
          $error("FAIL kernel_data observed=%0h expected=%0h", kif.kernel_data, exp_q[0]);
        end
        chk("kernel_idx", 64'(kif.kernel_idx), 64'(exp_idx_q[0]));
        chk("kernel_cksum", 64'(kif.kernel_cksum), 64'(exp_ck_q[0]));
        if (kif.kernel_ready) begin
          void'(exp_q.pop_front());
          void'(exp_idx_q.pop_front());
          void'(exp_ck_q.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_busy"},  64'(busy), 64'(0));
    chk({pfx, "_done"},  64'(done), 64'(0));
    chk({pfx, "_rd_en"}, 64'(rom_rd_en), 64'(0));
    chk({pfx, "_addr"},  64'(rom_addr), 64'(0));
    chk({pfx, "_valid"}, 64'(kif.kernel_valid), 64'(0));
    chk({pfx, "_idx"},   64'(kif.kernel_idx), 64'(0));
    chk({pfx, "_cksum"}, 64'(kif.kernel_cksum), 64'(0));
    chk({pfx, "_state"}, 64'(state), 64'(IDLE));
    checks++;
    assert (kif.kernel_data === '0) else begin
      errors++;
      $error("FAIL %s_data observed=%0h expected=0", pfx, kif.kernel_data);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    start = 1'b0;
    kif.kernel_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Run 1: ready held high throughout.
    kif.kernel_ready = 1'b1;
    push_run();
    rd_base = rd_cnt;
    pulse_start();
    chk("run1_busy_after_start", 64'(busy), 64'(1));
    n = 0;
    while (!kif.kernel_valid && n < 200) begin
      tick();
      n++;
    end
    chk("first_valid_latency", 64'(n), 64'(37));
    chk("cksum_set0", 64'(kif.kernel_cksum), 64'(CK_SET0));
    n = 0;
    seen7 = 1'b0;
    while (!done && n < 2000) begin
      if (kif.kernel_valid && kif.kernel_idx == KIDX_W'(7) && !seen7) begin
        chk("cksum_set7", 64'(kif.kernel_cksum), 64'(CK_SET7));
        seen7 = 1'b1;
      end
      tick();
      n++;
    end
    chk("run1_done", 64'(done), 64'(1));
    chk("run1_set7_seen", 64'(seen7), 64'(1));
    chk("run1_busy_in_done", 64'(busy), 64'(1));
    tick();
    tick();
    chk("run1_done_count", 64'(done_cnt), 64'(1));
    chk("run1_busy_after", 64'(busy), 64'(0));
    chk("run1_reads", 64'(rd_cnt - rd_base), 64'(288));
    chk("run1_queue_empty", 64'(exp_q.size()), 64'(0));

    // Run 2: stall set 2, stray start at set 4 and during DONE.
    push_run();
    rd_base = rd_cnt;
    pulse_start();
    n = 0;
    while (kif.kernel_idx != KIDX_W'(2) && n < 500) begin
      tick();
      n++;
    end
    chk("reach_set2", 64'(kif.kernel_idx), 64'(2));
    kif.kernel_ready = 1'b0;
    n = 0;
    while (!kif.kernel_valid && n < 100) begin
      tick();
      n++;
    end
    chk("set2_valid", 64'(kif.kernel_valid), 64'(1));
    snap = kif.kernel_data;
    repeat (5) tick();
    checks++;
    assert (kif.kernel_data === snap) else begin
      errors++;
      $error("FAIL set2_stable observed=%0h expected=%0h", kif.kernel_data, snap);
    end
    chk("set2_idx_held", 64'(kif.kernel_idx), 64'(2));
    chk("set2_valid_held", 64'(kif.kernel_valid), 64'(1));
    chk("set2_state_hold", 64'(state), 64'(HOLD));
    kif.kernel_ready = 1'b1;
    tick();
    chk("set3_valid_dropped", 64'(kif.kernel_valid), 64'(0));
    chk("set3_rd_en", 64'(rom_rd_en), 64'(1));
    chk("set3_addr", 64'(rom_addr), 64'(108));
    chk("set3_idx", 64'(kif.kernel_idx), 64'(3));
    n = 0;
    while (kif.kernel_idx != KIDX_W'(4) && n < 500) begin
      tick();
      n++;
    end
    pulse_start();
    chk("busy_start_idx", 64'(kif.kernel_idx), 64'(4));
    chk("busy_start_addr", 64'(rom_addr), 64'(145));
    chk("busy_start_state", 64'(state), 64'(FETCH));
    n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    chk("run2_done", 64'(done), 64'(1));
    pulse_start();
    chk("done_start_state", 64'(state), 64'(IDLE));
    chk("done_start_busy", 64'(busy), 64'(0));
    tick();
    tick();
    chk("done_start_rd_en", 64'(rom_rd_en), 64'(0));
    chk("run2_done_count", 64'(done_cnt), 64'(2));
    chk("run2_reads", 64'(rd_cnt - rd_base), 64'(288));
    chk("run2_queue_empty", 64'(exp_q.size()), 64'(0));

    // Run 3: restart from zero, then abort with reset mid-FETCH of set 5.
    push_run();
    pulse_start();
    chk("restart_addr", 64'(rom_addr), 64'(0));
    chk("restart_idx", 64'(kif.kernel_idx), 64'(0));
    chk("restart_rd_en", 64'(rom_rd_en), 64'(1));
    n = 0;
    while (!(kif.kernel_idx == KIDX_W'(5) && rom_rd_en && rom_addr == ADDR_W'(190)) && n < 1000) begin
      tick();
      n++;
    end
    chk("abort_point_addr", 64'(rom_addr), 64'(190));
    dc = done_cnt;
    #2 rst = 1'b1;
    #1;
    check_all_zero("abort");
    exp_q.delete();
    exp_idx_q.delete();
    exp_ck_q.delete();
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", 64'(done_cnt), 64'(dc));
    chk("abort_state_idle", 64'(state), 64'(IDLE));

    // Run 4: fresh start after abort, random backpressure.
    push_run();
    rd_base = rd_cnt;
    pulse_start();
    chk("fresh_addr", 64'(rom_addr), 64'(0));
    chk("fresh_rd_en", 64'(rom_rd_en), 64'(1));
    n = 0;
    while (!done && n < 6000) begin
      kif.kernel_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("run4_done", 64'(done), 64'(1));
    tick();
    tick();
    chk("run4_done_count", 64'(done_cnt), 64'(dc + 1));
    chk("run4_reads", 64'(rd_cnt - rd_base), 64'(288));
    chk("run4_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
